// File: rtl/axil_dram.sv
// axil_dram: AXI4-Lite slave data RAM, 32-bit words, byte-writable.
//
// Parameters
//   AW      word-index width (byte address bits [AW+1:2] select the word)
//   DEPTH   implemented words, DEPTH <= 2**AW
//   RD_WAIT extra cycles between AR accept and rvalid (0..15)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   dram_axi_aw* / w* / b*   write address, data and response channels
//   dram_axi_ar* / r*        read address and data channels
//
// AW and W are accepted together in one cycle; B is registered. Reads run
// through a small FSM (idle / wait / respond) with a launch-on-accept RAM
// read, so a read and a write to the same word in one cycle see old data.
// Out-of-range accesses never touch the RAM and answer SLVERR.
module axil_dram #(
    parameter int AW      = 12,
    parameter int DEPTH   = 4096,
    parameter int RD_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dram_axi_awaddr,
    input  logic [2:0]  dram_axi_awprot,
    input  logic        dram_axi_awvalid,
    output logic        dram_axi_awready,
    input  logic [31:0] dram_axi_wdata,
    input  logic [3:0]  dram_axi_wstrb,
    input  logic        dram_axi_wvalid,
    output logic        dram_axi_wready,
    output logic [1:0]  dram_axi_bresp,
    output logic        dram_axi_bvalid,
    input  logic        dram_axi_bready,
    input  logic [31:0] dram_axi_araddr,
    input  logic [2:0]  dram_axi_arprot,
    input  logic        dram_axi_arvalid,
    output logic        dram_axi_arready,
    output logic [31:0] dram_axi_rdata,
    output logic [1:0]  dram_axi_rresp,
    output logic        dram_axi_rvalid,
    input  logic        dram_axi_rready
);

    localparam int        IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [1:0] SLVERR    = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    // Range check: upper bits above the word index must be zero (no
    // aliasing) and the index must fall inside the implemented depth.
    function automatic logic in_range(input logic [31:0] a);
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        return ((a >> (AW + 2)) == 32'd0) &&
               ({{(32-AW){1'b0}}, idx} < 32'(DEPTH));
    endfunction

    logic [31:0] mem [DEPTH];

    logic unused_prot;
    assign unused_prot = ^{dram_axi_awprot, dram_axi_arprot};

    // ---------------- write channel ----------------
    logic          wr_acc;
    logic          wr_ok;
    logic [AW-1:0] widx;

    assign wr_acc = dram_axi_awvalid & dram_axi_wvalid &
                    (~dram_axi_bvalid | dram_axi_bready);
    assign dram_axi_awready = wr_acc;
    assign dram_axi_wready  = wr_acc;
    assign wr_ok = in_range(dram_axi_awaddr);
    assign widx  = dram_axi_awaddr[AW+1:2];

    // RAM array has no reset: committed contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_acc && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (dram_axi_wstrb[i])
                    mem[widx[IW-1:0]][8*i +: 8] <= dram_axi_wdata[8*i +: 8];
            end
        end
    end

    // A fresh accept wins over retirement, so bvalid stays up across
    // back-to-back writes with bready held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_axi_bvalid <= 1'b0;
            dram_axi_bresp  <= OKAY;
        end else if (wr_acc) begin
            dram_axi_bvalid <= 1'b1;
            dram_axi_bresp  <= wr_ok ? OKAY : SLVERR;
        end else if (dram_axi_bready) begin
            dram_axi_bvalid <= 1'b0;
        end
    end

    // ---------------- read channel ----------------
    rstate_t       rstate, rnext;
    logic [3:0]    rcnt;
    logic          rd_acc;
    logic          rd_ok;
    logic [AW-1:0] ridx;

    assign rd_acc = (rstate == R_IDLE) & dram_axi_arvalid;
    assign rd_ok  = in_range(dram_axi_araddr);
    assign ridx   = dram_axi_araddr[AW+1:2];

    assign dram_axi_arready = (rstate == R_IDLE);
    assign dram_axi_rvalid  = (rstate == R_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rcnt   <= 4'd0;
        end else begin
            rstate <= rnext;
            if (rd_acc)
                rcnt <= WAIT_INIT;
            else if (rstate == R_WAIT && rcnt != 4'd0)
                rcnt <= rcnt - 4'd1;
        end
    end

    always_comb begin
        rnext = rstate;
        case (rstate)
            R_IDLE: if (dram_axi_arvalid) rnext = (RD_WAIT > 0) ? R_WAIT : R_RESP;
            R_WAIT: if (rcnt == 4'd0)     rnext = R_RESP;
            R_RESP: if (dram_axi_rready)  rnext = R_IDLE;
            default:                      rnext = R_IDLE;
        endcase
    end

    // Data is captured at accept and held until the next accept, which
    // keeps rdata stable under backpressure and gives old-data semantics
    // against a write committed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_axi_rdata <= 32'd0;
            dram_axi_rresp <= OKAY;
        end else if (rd_acc) begin
            dram_axi_rdata <= rd_ok ? mem[ridx[IW-1:0]] : 32'd0;
            dram_axi_rresp <= rd_ok ? OKAY : SLVERR;
        end
    end

endmodule

// File: tb/tb_axil_dram.sv
// Bench for axil_dram: two instances (RD_WAIT=0 and RD_WAIT=3) share one
// stimulus stream; a word-array model predicts data and responses.
module tb_axil_dram;

    localparam int DEPTH = 4096;
    localparam int NM    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic [1:0]        awready, wready, bvalid, arready, rvalid;
    logic [1:0][1:0]   bresp, rresp;
    logic [1:0][31:0]  rdata;

    int ncmp = 0;
    int nfail = 0;
    logic [31:0] model [NM];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axil_dram #(.AW(12), .DEPTH(DEPTH), .RD_WAIT(g * 3)) dut (
            .clk(clk), .rst_n(rst_n),
            .dram_axi_awaddr(awaddr), .dram_axi_awprot(3'd0),
            .dram_axi_awvalid(awvalid), .dram_axi_awready(awready[g]),
            .dram_axi_wdata(wdata), .dram_axi_wstrb(wstrb),
            .dram_axi_wvalid(wvalid), .dram_axi_wready(wready[g]),
            .dram_axi_bresp(bresp[g]), .dram_axi_bvalid(bvalid[g]),
            .dram_axi_bready(bready),
            .dram_axi_araddr(araddr), .dram_axi_arprot(3'd0),
            .dram_axi_arvalid(arvalid), .dram_axi_arready(arready[g]),
            .dram_axi_rdata(rdata[g]), .dram_axi_rresp(rresp[g]),
            .dram_axi_rvalid(rvalid[g]), .dram_axi_rready(rready)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ok_addr(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return ok_addr(a) ? model[(a >> 2) % NM] : 32'd0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return ok_addr(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (ok_addr(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model[(a >> 2) % NM][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'(4 * DEPTH + 4 * $urandom_range(0, NM - 1));
        if (sel == 1) return 32'h8000_0000 | 32'(4 * $urandom_range(0, NM - 1));
        return 32'(4 * $urandom_range(0, NM - 1) + $urandom_range(0, 3));
    endfunction

    // One write; checks joint accept now and B one cycle later.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er;
        er = exp_resp(a);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("awready%0d", i), 32'(awready[i]), 32'd1);
            chk($sformatf("wready%0d", i), 32'(wready[i]), 32'd1);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        model_wr(a, d, s);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bvalid%0d", i), 32'(bvalid[i]), 32'd1);
            chk($sformatf("bresp%0d", i), 32'(bresp[i]), 32'(er));
        end
    endtask

    // One read with rready high, optionally paired with a same-cycle write.
    task automatic do_read(input logic [31:0] a, input logic wr, input logic [31:0] wd);
        logic [31:0] ed;
        logic [1:0]  er, ebr;
        logic [1:0]  seen;
        ed = exp_rd(a); er = exp_resp(a); ebr = exp_resp(a);
        seen = 2'b00;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        if (wr) begin
            awaddr = a; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        end
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("arready_idle%0d", i), 32'(arready[i]), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        if (wr) begin
            awvalid = 1'b0; wvalid = 1'b0;
            model_wr(a, wd, 4'hF);
            for (int i = 0; i < 2; i++) chk($sformatf("coll_bresp%0d", i), 32'(bresp[i]), 32'(ebr));
        end
        for (int i = 0; i < 2; i++) chk($sformatf("arready_busy%0d", i), 32'(arready[i]), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (rvalid[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("rd_lat%0d", i), 32'(k), 32'(1 + 3 * i));
                    chk($sformatf("rdata%0d", i), rdata[i], ed);
                    chk($sformatf("rresp%0d", i), 32'(rresp[i]), 32'(er));
                end
            end
            if (awvalid && !wvalid) begin
                chk("lone_aw_awready", 32'(awready), 32'd0);
                chk("lone_aw_bvalid", 32'(bvalid), 32'd0);
            end
            @(negedge clk);
        end
        chk("rd_seen", 32'(seen), 32'd3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold0, hold1, a, d;
        rst_n = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_bvalid%0d", i), 32'(bvalid[i]), 32'd0);
            chk($sformatf("rst_bresp%0d", i), 32'(bresp[i]), 32'd0);
            chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
            chk($sformatf("rst_rresp%0d", i), 32'(rresp[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            chk($sformatf("rst_arready%0d", i), 32'(arready[i]), 32'd1);
            chk($sformatf("rst_awready%0d", i), 32'(awready[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Fill the tracked words so every later read has a known value.
        for (int i = 0; i < NM; i++) do_write(32'(4 * i), $urandom, 4'hF);

        do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h10, 1'b0, 32'd0);
        do_write(32'h20, 32'h1122_3344, 4'hF);
        do_write(32'h20, 32'hAABB_CCDD, 4'b0101);
        chk("strb_model", model[8], 32'h11BB_33DD);
        do_read(32'h20, 1'b0, 32'd0);
        do_write(32'h24, 32'hFFFF_FFFF, 4'b0000);
        do_read(32'h24, 1'b0, 32'd0);

        // Lone AW held across a complete read.
        awvalid = 1'b1; awaddr = 32'h14;
        do_read(32'h10, 1'b0, 32'd0);
        awvalid = 1'b0;

        // Out of range: no aliasing onto index 0.
        do_read(32'(4 * DEPTH), 1'b0, 32'd0);
        do_write(32'(4 * DEPTH), 32'h5555_AAAA, 4'hF);
        do_read(32'h0, 1'b0, 32'd0);

        // Backpressure on R with rready low for two cycles of rvalid on the slow instance.
        rready = 1'b0;
        @(negedge clk); araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        chk("bp_rvalid0_k1", 32'(rvalid[0]), 32'd1);
        hold0 = rdata[0];
        chk("bp_rdata0", hold0, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        chk("bp_rvalid1_k4", 32'(rvalid[1]), 32'd1);
        hold1 = rdata[1];
        chk("bp_rdata1", hold1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("bp_rvalid1_k5", 32'(rvalid[1]), 32'd1);
        chk("bp_hold1", rdata[1], hold1);
        chk("bp_hold0", rdata[0], hold0);
        chk("bp_arready1_low", 32'(arready[1]), 32'd0);
        rready = 1'b1;
        @(negedge clk);
        chk("bp_rvalid_done", 32'(rvalid), 32'd0);
        chk("bp_arready_back", 32'(arready), 32'd3);

        // Same-cycle read and write to one word: old data, then new.
        do_write(32'h30, 32'h0, 4'hF);
        do_read(32'h30, 1'b1, 32'h5);
        do_read(32'h30, 1'b0, 32'd0);

        // Reset in the middle of the slow instance's wait phase.
        @(negedge clk); araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid_arready", 32'(arready), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(32'h20, 1'b0, 32'd0);

        // Randomized mix against the model.
        for (int n = 0; n < 60; n++) begin
            a = rnd_addr();
            d = $urandom;
            case ($urandom_range(0, 2))
                0:       do_write(a, d, 4'($urandom_range(0, 15)));
                1:       do_read(a, 1'b0, 32'd0);
                default: do_read(a, 1'b1, d);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
